// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction tree with a per-packet accumulator and a
// saturating/wrapping result stage on a valid/ready stream.
module pipelined_adder_tree #(
    parameter int unsigned N_OPERANDS = 16,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [N_OPERANDS*IN_WIDTH-1:0]   in_data_i,
    input  logic                             in_first_i,
    input  logic                             in_last_i,
    input  logic                             sat_en_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [OUT_WIDTH-1:0]             out_data_o
);

    localparam int unsigned LEVELS    = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 0;
    localparam int unsigned N_PAD     = 1 << LEVELS;
    localparam int unsigned SUM_WIDTH = IN_WIDTH + LEVELS;

    // Clamp bounds for the saturating conversion, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic                          w_en;
    logic signed [IN_WIDTH-1:0]    w_op [N_PAD];
    logic signed [SUM_WIDTH-1:0]   w_s;
    logic                          w_s_valid;
    logic                          w_s_first;
    logic                          w_s_last;
    logic                          w_s_sat;
    logic signed [ACC_WIDTH-1:0]   w_s_ext;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;
    logic [OUT_WIDTH-1:0]          w_conv;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic                          r_out_valid;
    logic [OUT_WIDTH-1:0]          r_out_data;

    // Whole pipeline advances together; it only stops when a result is stuck at the output.
    assign w_en        = ~r_out_valid | out_ready_i;
    assign in_ready_o  = w_en;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

    // Unpack operands; lanes beyond N_OPERANDS are zero padding.
    for (genvar k = 0; k < N_PAD; k++) begin : g_op
        if (k < N_OPERANDS) begin : g_real
            assign w_op[k] = $signed(in_data_i[k*IN_WIDTH +: IN_WIDTH]);
        end else begin : g_pad
            assign w_op[k] = '0;
        end
    end

    // One register level per tree stage, each one bit wider than the level feeding it.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NL = N_PAD >> l;
        localparam int unsigned WL = IN_WIDTH + l;

        logic signed [WL-1:0] r_sum [NL];
        logic                 r_valid;
        logic                 r_first;
        logic                 r_last;
        logic                 r_sat;
        logic signed [WL-2:0] w_prev [2*NL];
        logic                 w_prev_valid;
        logic                 w_prev_first;
        logic                 w_prev_last;
        logic                 w_prev_sat;

        for (genvar k = 0; k < 2*NL; k++) begin : g_prev
            if (l == 1) begin : g_in
                assign w_prev[k] = w_op[k];
            end else begin : g_up
                assign w_prev[k] = g_lvl[l-1].r_sum[k];
            end
        end

        if (l == 1) begin : g_side_in
            assign w_prev_valid = in_valid_i;
            assign w_prev_first = in_first_i;
            assign w_prev_last  = in_last_i;
            assign w_prev_sat   = sat_en_i;
        end else begin : g_side_up
            assign w_prev_valid = g_lvl[l-1].r_valid;
            assign w_prev_first = g_lvl[l-1].r_first;
            assign w_prev_last  = g_lvl[l-1].r_last;
            assign w_prev_sat   = g_lvl[l-1].r_sat;
        end

        // Register pairwise sums and the beat sideband for this level.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
                r_sat   <= 1'b0;
                for (int k = 0; k < NL; k++) begin
                    r_sum[k] <= '0;
                end
            end else if (w_en) begin
                r_valid <= w_prev_valid;
                r_first <= w_prev_first;
                r_last  <= w_prev_last;
                r_sat   <= w_prev_sat;
                for (int k = 0; k < NL; k++) begin
                    r_sum[k] <= WL'(w_prev[2*k]) + WL'(w_prev[2*k+1]);
                end
            end
        end
    end

    // Beat sum seen by the accumulator: tree root, or the single operand when there is no tree.
    if (LEVELS == 0) begin : g_s_direct
        assign w_s       = w_op[0];
        assign w_s_valid = in_valid_i;
        assign w_s_first = in_first_i;
        assign w_s_last  = in_last_i;
        assign w_s_sat   = sat_en_i;
    end else begin : g_s_tree
        assign w_s       = g_lvl[LEVELS].r_sum[0];
        assign w_s_valid = g_lvl[LEVELS].r_valid;
        assign w_s_first = g_lvl[LEVELS].r_first;
        assign w_s_last  = g_lvl[LEVELS].r_last;
        assign w_s_sat   = g_lvl[LEVELS].r_sat;
    end

    assign w_s_ext = ACC_WIDTH'(w_s);

    // Next accumulator value and its conversion to the output width.
    always_comb begin
        w_acc_next = w_s_first ? w_s_ext : r_acc + w_s_ext;
        w_conv     = w_acc_next[OUT_WIDTH-1:0];
        if (w_s_sat) begin
            if (w_acc_next > SAT_MAX) begin
                w_conv = SAT_MAX[OUT_WIDTH-1:0];
            end else if (w_acc_next < SAT_MIN) begin
                w_conv = SAT_MIN[OUT_WIDTH-1:0];
            end
        end
    end

    // Accumulate valid beats and publish the result on the packet's last beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            if (w_s_valid) begin
                r_acc <= w_acc_next;
            end
            r_out_valid <= w_s_valid & w_s_last;
            if (w_s_valid & w_s_last) begin
                r_out_data <= w_conv;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree: table vectors, scoreboard,
// stall/reset sequences, plus a 5-operand instance for the padded tree.
module tb_pipelined_adder_tree;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         in_first_i;
    logic         in_last_i;
    logic         sat_en_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [15:0]  out_data_o;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [39:0]  b_in_data;
    logic         b_in_first;
    logic         b_in_last;
    logic         b_sat_en;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [15:0]  b_out_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    int model_acc = 0;
    int exp_q[$];

    typedef struct {
        logic [127:0] data;
        logic         sat;
        int           exp;
    } vec_t;
    vec_t tbl[6];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    pipelined_adder_tree dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_first_i  (in_first_i),
        .in_last_i   (in_last_i),
        .sat_en_i    (sat_en_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    pipelined_adder_tree #(.N_OPERANDS(5)) dut5 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .in_first_i  (b_in_first),
        .in_last_i   (b_in_last),
        .sat_en_i    (b_sat_en),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fill(input int v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic int beat_sum(input logic [127:0] d);
        int s = 0;
        for (int k = 0; k < 16; k++) s += int'($signed(d[k*8 +: 8]));
        return s;
    endfunction

    function automatic int conv(input int a, input logic s);
        if (s) begin
            if (a > 32767)  return 32767;
            if (a < -32768) return -32768;
            return a;
        end
        return int'(shortint'(a));
    endfunction

    // Scoreboard: every consumed result is compared with the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0d, expected no result", $signed(out_data_o));
            end else begin
                check("result", int'($signed(out_data_o)), exp_q.pop_front());
            end
        end
    end

    // Drive one beat and hold it until accepted; update the model on acceptance.
    task automatic send_beat(input logic [127:0] d, input logic f, input logic l,
                             input logic s, input logic has_exp, input int exp);
        bit ok = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_first_i = f;
        in_last_i  = l;
        sat_en_i   = s;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk_i);
            if (in_ready_o) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready_o=0, expected 1");
        end else begin
            t_acc     = cyc;
            model_acc = f ? beat_sum(d) : model_acc + beat_sum(d);
            if (l) exp_q.push_back(has_exp ? exp : conv(model_acc, s));
        end
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_first_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [127:0] d;
        int lat;
        int held;

        rst_ni = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0; in_first_i = 1'b0; in_last_i = 1'b0; sat_en_i = 1'b0;
        out_ready_i = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_first = 1'b0; b_in_last = 1'b0; b_sat_en = 1'b0;
        b_out_ready = 1'b1;

        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(k + 1);
        tbl[0] = '{fill(127),  1'b0, 2032};
        tbl[1] = '{fill(-128), 1'b1, -2048};
        tbl[2] = '{d,          1'b0, 136};
        tbl[3] = '{fill(-1),   1'b0, -16};
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = (k % 2 == 0) ? 8'd127 : 8'h80;
        tbl[4] = '{d,          1'b0, -8};
        tbl[5] = '{fill(0),    1'b1, 0};

        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_b_out_valid", b_out_valid, 0);

        // Single beat, latency LEVELS+1
        send_beat(fill(127), 1'b1, 1'b1, 1'b0, 1'b1, 2032);
        idle();
        lat = -1;
        for (int w = 0; w < 20 && lat < 0; w++) begin
            @(negedge clk_i);
            if (out_valid_o) lat = cyc - t_acc;
        end
        check("latency16", lat, 5);
        drain(8);

        // Back-to-back one-beat packets from the table
        for (int i = 0; i < 6; i++) begin
            send_beat(tbl[i].data, 1'b1, 1'b1, tbl[i].sat, 1'b1, tbl[i].exp);
        end
        idle();
        drain(10);

        // 20-beat packets: saturate, then wrap, then negative saturate
        for (int b = 0; b < 20; b++) send_beat(fill(127), b == 0, b == 19, 1'b1, 1'b1, 32767);
        for (int b = 0; b < 20; b++) send_beat(fill(127), b == 0, b == 19, 1'b0, 1'b1, -24896);
        for (int b = 0; b < 20; b++) send_beat(fill(-128), b == 0, b == 19, 1'b1, 1'b1, -32768);
        idle();
        drain(10);

        // Mid-packet restart drops the partial sum; first=0 continues the accumulator
        send_beat(fill(5), 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_beat(fill(2), 1'b1, 1'b1, 1'b0, 1'b1, 32);
        send_beat(fill(1), 1'b0, 1'b1, 1'b0, 1'b1, 48);
        idle();
        drain(10);

        // Continuous traffic with a 10-cycle downstream stall
        fork
            begin
                logic [127:0] rd;
                for (int i = 0; i < 16; i++) begin
                    rd = {$urandom, $urandom, $urandom, $urandom};
                    send_beat(rd, 1'b1, 1'b1, 1'(i % 2), 1'b0, 0);
                end
                idle();
            end
            begin
                repeat (8) @(posedge clk_i);
                #1 out_ready_i = 1'b0;
                held = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk_i);
                    check("stall_in_ready", in_ready_o, 0);
                    check("stall_out_valid", out_valid_o, 1);
                    if (c > 0) check("stall_data_stable", int'($signed(out_data_o)), held);
                    held = int'($signed(out_data_o));
                end
                @(posedge clk_i); #1 out_ready_i = 1'b1;
            end
        join
        drain(30);

        // Reset mid-packet discards in-flight beats and the accumulator
        send_beat(fill(3), 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_beat(fill(3), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_beat(fill(3), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        @(posedge clk_i); #1;
        rst_ni     = 1'b1;
        model_acc  = 0;
        @(negedge clk_i);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_in_ready", in_ready_o, 1);
        drain(8);
        send_beat(fill(1), 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_beat(fill(1), 1'b0, 1'b1, 1'b0, 1'b1, 32);
        idle();
        drain(10);

        // Five-operand build: padded to 8 lanes, three levels
        @(posedge clk_i); #1;
        b_in_valid = 1'b1;
        b_in_data  = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        b_in_first = 1'b1;
        b_in_last  = 1'b1;
        @(negedge clk_i);
        check("n5_in_ready", b_in_ready, 1);
        t_acc = cyc;
        @(posedge clk_i); #1;
        b_in_valid = 1'b0;
        lat = -1;
        for (int w = 0; w < 20 && lat < 0; w++) begin
            @(negedge clk_i);
            if (b_out_valid) lat = cyc - t_acc;
        end
        check("latency5", lat, 4);
        check("n5_result", int'($signed(b_out_data)), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
